// File: rtl/spi_burst_master_if.sv
// rtl/spi_burst_master_if.sv - control, byte-stream and SPI pin bundle for the burst master
interface spi_burst_master_if #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8,
   parameter int BURST_W = 4
);
   logic               start;
   logic               rw;
   logic [ADDR_W-1:0]  addr;
   logic [BURST_W-1:0] burst_len;
   logic [DATA_W-1:0]  wr_data;
   logic               wr_valid;
   logic               wr_ready;
   logic [DATA_W-1:0]  rd_data;
   logic               rd_valid;
   logic               busy;
   logic               done;
   logic               spi_sclk;
   logic               spi_cs_n;
   logic               spi_mosi;
   logic               spi_miso;

   // the SPI master itself
   modport master (
      input  start, rw, addr, burst_len, wr_data, wr_valid, spi_miso,
      output wr_ready, rd_data, rd_valid, busy, done, spi_sclk, spi_cs_n, spi_mosi
   );

   // the controller / sensor side
   modport slave (
      output start, rw, addr, burst_len, wr_data, wr_valid, spi_miso,
      input  wr_ready, rd_data, rd_valid, busy, done, spi_sclk, spi_cs_n, spi_mosi
   );
endinterface

// File: rtl/spi_burst_master.sv
// rtl/spi_burst_master.sv - mode-3 SPI master sending a header byte plus a data burst per CS frame
module spi_burst_master #(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 8,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   spi_burst_master_if.master bus
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int REQ_W = BURST_W + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HDR, DATA, HOLD} state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [BURST_W-1:0] byte_cnt;
   logic [BURST_W-1:0] len_q;
   logic               rw_q;
   logic [DATA_W-1:0]  sh;
   logic [DATA_W-2:0]  rx;
   logic [DATA_W-1:0]  hold_reg;
   logic               hold_full;
   logic [REQ_W-1:0]   req_left;
   logic               sclk_q;
   logic               cs_n_q;
   logic               mosi_q;
   logic               busy_q;
   logic               done_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic               rd_valid_q;
   logic [DATA_W-1:0]  hdr;
   logic               wr_ready_w;
   logic               wr_fire;

   // header byte {rw, multi-byte flag, start address}
   assign hdr        = {bus.rw, |bus.burst_len, bus.addr[ADDR_W-1:0]};
   // ask for write bytes only while there is room and the burst still needs bytes
   assign wr_ready_w = busy_q & ~rw_q & ~hold_full & (req_left != '0);
   assign wr_fire    = bus.wr_valid & wr_ready_w;

   assign bus.wr_ready = wr_ready_w;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.spi_sclk = sclk_q;
   assign bus.spi_cs_n = cs_n_q;
   assign bus.spi_mosi = mosi_q;

   // frame sequencer: SCLK generation, shifting, holding register and stream handshakes
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         len_q      <= '0;
         rw_q       <= 1'b0;
         sh         <= '0;
         rx         <= '0;
         hold_reg   <= '0;
         hold_full  <= 1'b0;
         req_left   <= '0;
         sclk_q     <= 1'b1;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         if (wr_fire) begin
            hold_reg  <= bus.wr_data;
            hold_full <= 1'b1;
            req_left  <= req_left - REQ_W'(1);
         end
         case (state)
            IDLE: begin
               // busy is still high in the done cycle, so a start there is dropped
               busy_q <= 1'b0;
               if (bus.start && !busy_q) begin
                  rw_q     <= bus.rw;
                  len_q    <= bus.burst_len;
                  req_left <= bus.rw ? '0 : REQ_W'(bus.burst_len) + REQ_W'(1);
                  sh       <= hdr;
                  mosi_q   <= hdr[DATA_W-1];
                  cs_n_q   <= 1'b0;
                  busy_q   <= 1'b1;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else begin
                  sclk_q  <= 1'b0;
                  mosi_q  <= sh[DATA_W-1];
                  sh      <= sh << 1;
                  div_cnt <= '0;
                  state   <= HDR;
               end
            end
            HDR, DATA: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else if (!sclk_q) begin
                  // rising edge: miso has been stable since the slave's falling-edge update
                  sclk_q  <= 1'b1;
                  div_cnt <= '0;
                  rx      <= {rx[DATA_W-3:0], bus.spi_miso};
                  if (state == DATA && rw_q && bit_cnt == BIT_LAST) begin
                     rd_data_q  <= {rx, bus.spi_miso};
                     rd_valid_q <= 1'b1;
                  end
               end else if (bit_cnt != BIT_LAST) begin
                  sclk_q  <= 1'b0;
                  div_cnt <= '0;
                  mosi_q  <= sh[DATA_W-1];
                  sh      <= sh << 1;
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end else if (state == DATA && byte_cnt == len_q) begin
                  div_cnt <= '0;
                  state   <= HOLD;
               end else if (rw_q || hold_full) begin
                  sclk_q  <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  mosi_q  <= rw_q ? 1'b0 : hold_reg[DATA_W-1];
                  sh      <= rw_q ? '0 : {hold_reg[DATA_W-2:0], 1'b0};
                  if (!rw_q) hold_full <= 1'b0;
                  if (state == DATA) byte_cnt <= byte_cnt + BURST_W'(1);
                  state   <= DATA;
               end
               // otherwise a write byte is missing: SCLK parks high with the divider at its last count
            end
            HOLD: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else begin
                  cs_n_q <= 1'b1;
                  mosi_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_burst_master.sv
// tb/tb_spi_burst_master.sv - directed scoreboard bench for spi_burst_master
module tb_spi_burst_master;
   localparam int CLK_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   start_cyc = 0;

   logic [7:0] mosi_exp[$];
   logic [7:0] rd_exp[$];
   logic [7:0] miso_src[$];

   int   frames = 0, rises = 0, rif = 0, run = 0, max_run = 0;
   int   rd_count = 0, done_count = 0, wr_ready_cycles = 0;
   logic prev_sclk = 1'b1, prev_cs_n = 1'b1;
   logic [7:0] bitbuf = 8'h00;
   logic [7:0] slave_byte = 8'h00;

   spi_burst_master_if #(.ADDR_W(6), .DATA_W(8), .BURST_W(4)) bus ();

   spi_burst_master #(.CLK_DIV(CLK_DIV), .ADDR_W(6), .DATA_W(8), .BURST_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_len(input int len);
      return (1 + CLK_DIV) + 16 * CLK_DIV * (len + 2) + CLK_DIV;
   endfunction

   // mode-3 slave model and output scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) bus.spi_miso = 1'b0;
      if (prev_cs_n && !bus.spi_cs_n) begin
         frames++; rif = 0; run = 0; max_run = 0;
      end
      if (!bus.spi_cs_n) begin
         if (!prev_sclk && bus.spi_sclk) begin
            rises++; rif++;
            bitbuf = {bitbuf[6:0], bus.spi_mosi};
            if (rif % 8 == 0) begin
               e = (mosi_exp.size() != 0) ? {24'd0, mosi_exp.pop_front()} : 32'hFFFF_FFFF;
               check("mosi_byte", {24'd0, bitbuf}, e);
            end
         end
         if (prev_sclk && !bus.spi_sclk) begin
            if (rif >= 8 && rif % 8 == 0)
               slave_byte = (miso_src.size() != 0) ? miso_src.pop_front() : 8'h00;
            bus.spi_miso = slave_byte[7 - (rif % 8)];
         end
         if (bus.spi_sclk) run++; else run = 0;
         if (run > max_run) max_run = run;
      end
      if (bus.rd_valid) begin
         rd_count++;
         e = (rd_exp.size() != 0) ? {24'd0, rd_exp.pop_front()} : 32'hFFFF_FFFF;
         check("rd_data", {24'd0, bus.rd_data}, e);
      end
      if (bus.done) done_count++;
      if (bus.wr_ready) wr_ready_cycles++;
      prev_sclk = bus.spi_sclk;
      prev_cs_n = bus.spi_cs_n;
   end

   task automatic start_frame(input logic rw, input logic [5:0] addr, input logic [3:0] len);
      bus.rw = rw; bus.addr = addr; bus.burst_len = len; bus.start = 1'b1;
      start_cyc = cyc;
      mosi_exp.push_back({rw, len != 4'd0, addr});
      if (rw) for (int i = 0; i <= int'(len); i++) mosi_exp.push_back(8'h00);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      bus.wr_data = d; bus.wr_valid = 1'b1;
      mosi_exp.push_back(d);
      while (bus.wr_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check("wr_accept", bus.wr_ready, 1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int lat);
      int n = 0;
      while (bus.done !== 1'b1 && n < bound) begin @(negedge clk); n++; end
      check("done_seen", bus.done, 1);
      lat = cyc - start_cyc;
   endtask

   initial begin
      int lat, f0, d0, r0, rd0, w0, stall;
      logic [7:0] b;
      bus.start = 0; bus.rw = 0; bus.addr = 0; bus.burst_len = 0;
      bus.wr_data = 0; bus.wr_valid = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cs_n", bus.spi_cs_n, 1);
      check("rst_sclk", bus.spi_sclk, 1);
      check("rst_mosi", bus.spi_mosi, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_wr_ready", bus.wr_ready, 0);
      check("rst_rd_data", bus.rd_data, 0);

      // 1: single write, addr 0x2D, data 0x08
      f0 = frames;
      start_frame(1'b0, 6'h2D, 4'd0);
      check("t1_busy_after_start", bus.busy, 1);
      check("t1_cs_low", bus.spi_cs_n, 0);
      send_byte(8'h08);
      wait_done(1000, lat);
      check("t1_latency", lat, frame_len(0));
      check("t1_done_cs_n", bus.spi_cs_n, 1);
      check("t1_done_busy", bus.busy, 1);
      @(negedge clk);
      check("t1_done_pulse", bus.done, 0);
      check("t1_busy_drop", bus.busy, 0);
      check("t1_rises", rif, 16);
      check("t1_max_high", max_run, 2 * CLK_DIV);
      check("t1_frames", frames - f0, 1);
      check("t1_mosi_left", mosi_exp.size(), 0);

      // 2: six-byte read burst from 0x32
      f0 = frames; rd0 = rd_count; w0 = wr_ready_cycles;
      for (int i = 1; i <= 6; i++) begin
         b = 8'(i * 17);
         miso_src.push_back(b); rd_exp.push_back(b);
      end
      start_frame(1'b1, 6'h32, 4'd5);
      wait_done(2000, lat);
      @(negedge clk);
      check("t2_latency", lat, frame_len(5));
      check("t2_rd_count", rd_count - rd0, 6);
      check("t2_frames", frames - f0, 1);
      check("t2_rises", rif, 56);
      check("t2_wr_ready", wr_ready_cycles - w0, 0);
      check("t2_rd_left", rd_exp.size(), 0);
      check("t2_mosi_left", mosi_exp.size(), 0);

      // 3: three-byte write with the second byte held back past its slot
      start_frame(1'b0, 6'h1A, 4'd2);
      send_byte(8'hA5);
      while (cyc < start_cyc + 172) @(negedge clk);
      send_byte(8'h3C);
      send_byte(8'hF0);
      wait_done(2000, lat);
      stall = (172 + 2) - (1 + CLK_DIV + 16 * CLK_DIV * 2);
      @(negedge clk);
      check("t3_latency", lat, frame_len(2) + stall);
      check("t3_max_high", max_run, CLK_DIV + stall);
      check("t3_rises", rif, 32);
      check("t3_mosi_left", mosi_exp.size(), 0);

      // 4: reset in the middle of a data byte, then a clean read
      d0 = done_count; rd0 = rd_count;
      start_frame(1'b0, 6'h0A, 4'd3);
      send_byte(8'h81);
      while (cyc < start_cyc + 100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t4_cs_n", bus.spi_cs_n, 1);
      check("t4_sclk", bus.spi_sclk, 1);
      check("t4_busy", bus.busy, 0);
      check("t4_wr_ready", bus.wr_ready, 0);
      repeat (300) @(negedge clk);
      check("t4_no_done", done_count - d0, 0);
      check("t4_no_rd", rd_count - rd0, 0);
      mosi_exp.delete(); rd_exp.delete(); miso_src.delete();
      miso_src.push_back(8'hC3); rd_exp.push_back(8'hC3);
      miso_src.push_back(8'h3C); rd_exp.push_back(8'h3C);
      start_frame(1'b1, 6'h15, 4'd1);
      wait_done(2000, lat);
      @(negedge clk);
      check("t4_latency", lat, frame_len(1));
      check("t4_rd_left", rd_exp.size(), 0);
      check("t4_mosi_left", mosi_exp.size(), 0);

      // 5: start with reset, start mid-frame and start in the done cycle are all dropped
      f0 = frames;
      bus.rw = 1'b0; bus.addr = 6'h11; bus.burst_len = 4'd0;
      bus.start = 1'b1; rst = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; rst = 1'b0;
      check("t5_rst_start_busy", bus.busy, 0);
      repeat (20) @(negedge clk);
      check("t5_rst_start_frames", frames - f0, 0);
      d0 = done_count;
      start_frame(1'b0, 6'h20, 4'd0);
      send_byte(8'h5A);
      while (cyc < start_cyc + 60) @(negedge clk);
      bus.rw = 1'b1; bus.addr = 6'h3F; bus.burst_len = 4'd3; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(1000, lat);
      check("t5_latency", lat, frame_len(0));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("t5_done_start_busy", bus.busy, 0);
      repeat (300) @(negedge clk);
      check("t5_frames", frames - f0, 1);
      check("t5_dones", done_count - d0, 1);

      // 6: maximum burst read, 16 bytes
      r0 = rises; rd0 = rd_count;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom_range(0, 255));
         miso_src.push_back(b); rd_exp.push_back(b);
      end
      start_frame(1'b1, 6'h05, 4'hF);
      wait_done(3000, lat);
      @(negedge clk);
      check("t6_latency", lat, frame_len(15));
      check("t6_rd_count", rd_count - rd0, 16);
      check("t6_rises", rises - r0, 136);
      check("t6_rd_left", rd_exp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
